// File: rtl/mc_pkg.sv
// mc_pkg: MIG user-port instruction codes and the write-issuer state type.
// Shared by every block that drives or decodes a MIG command port.
package mc_pkg;

   localparam logic [2:0] MIG_INSTR_WR = 3'b000;
   localparam logic [2:0] MIG_INSTR_RD = 3'b001;

   typedef enum logic [1:0] {
      WAIT_CAL,
      FILL,
      ISSUE,
      DONE
   } mc_state_e;

endpackage

// File: rtl/mc_wr_burst_issuer.sv
// mc_wr_burst_issuer: loads BURST_LEN source words into the MIG port-0 write FIFO,
// then issues one write command addressed at the first beat of the burst.
module mc_wr_burst_issuer
   import mc_pkg::*;
#(
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned MAX_BURSTS = 0,
   parameter logic [2:0]  WR_INSTR   = MIG_INSTR_WR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        calib_done,
   input  logic        src_valid,
   input  logic [30:0] src_word,
   output logic        src_rdy,
   output logic        p0_wr_en,
   output logic [31:0] p0_wr_data,
   output logic [3:0]  p0_wr_mask,
   input  logic        p0_wr_full,
   output logic        p0_cmd_en,
   output logic [2:0]  p0_cmd_instr,
   output logic [5:0]  p0_cmd_bl,
   output logic [29:0] p0_cmd_byte_addr,
   input  logic        p0_cmd_full,
   output logic [15:0] burst_cnt,
   output logic        align_err,
   output logic        done
);

   localparam logic [5:0]  LAST_BEAT = 6'(BURST_LEN - 1);
   localparam logic [15:0] MAX_CNT   = 16'(MAX_BURSTS);
   localparam bit          LIMITED   = (MAX_BURSTS != 0);

   mc_state_e   r_state;
   mc_state_e   w_state_nxt;
   logic [5:0]  r_beat_cnt;
   logic [15:0] r_burst_cnt;
   logic [29:0] r_addr_q;
   logic        r_cmd_en;
   logic        r_align_err;

   logic        w_src_rdy;
   logic        w_accept;
   logic        w_issue;
   logic        w_last_beat;
   logic        w_first_beat;
   logic [15:0] w_burst_nxt;

   assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
   assign w_first_beat = (r_beat_cnt == 6'd0);
   assign w_burst_nxt  = r_burst_cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= WAIT_CAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake is gated by rst so nothing is pushed while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_src_rdy   = 1'b0;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      unique case (r_state)
         WAIT_CAL: begin
            if (calib_done) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            w_src_rdy = !p0_wr_full && !rst;
            w_accept  = src_valid && w_src_rdy;
            if (w_accept && w_last_beat) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!p0_cmd_full) begin
               w_issue = 1'b1;
               if (LIMITED && (w_burst_nxt == MAX_CNT)) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = FILL;
               end
            end
         end
         DONE: begin
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = WAIT_CAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt  <= '0;
         r_burst_cnt <= '0;
         r_addr_q    <= '0;
         r_cmd_en    <= 1'b0;
         r_align_err <= 1'b0;
      end else begin
         r_cmd_en <= w_issue;
         if (w_issue) begin
            r_burst_cnt <= w_burst_nxt;
         end
         if (w_accept) begin
            if (w_last_beat) begin
               r_beat_cnt <= '0;
            end else begin
               r_beat_cnt <= r_beat_cnt + 6'd1;
            end
            // addr_q only moves on a new burst's first beat, after the pulse.
            if (w_first_beat) begin
               r_addr_q <= {src_word[29:2], 2'b00};
               if (src_word[1:0] != 2'b00) begin
                  r_align_err <= 1'b1;
               end
            end
         end
      end
   end

   assign src_rdy          = w_src_rdy;
   assign p0_wr_en         = w_accept;
   assign p0_wr_data       = {1'b0, src_word};
   assign p0_wr_mask       = 4'b0000;
   assign p0_cmd_en        = r_cmd_en;
   assign p0_cmd_instr     = WR_INSTR;
   assign p0_cmd_bl        = LAST_BEAT;
   assign p0_cmd_byte_addr = r_addr_q;
   assign burst_cnt        = r_burst_cnt;
   assign align_err        = r_align_err;
   assign done             = (r_state == DONE);

endmodule

// File: tb/tb_mc_wr_burst_issuer.sv
// tb_mc_wr_burst_issuer: vector table for handshake gating plus scoreboarded
// burst sequences for stalls, command back-pressure, burst limit and reset.
module tb_mc_wr_burst_issuer;

   localparam int BL   = 8;
   localparam int MAXB = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        calib_done = 1'b0;
   logic        src_valid = 1'b0;
   logic [30:0] src_word;
   logic        src_rdy;
   logic        p0_wr_en;
   logic [31:0] p0_wr_data;
   logic [3:0]  p0_wr_mask;
   logic        p0_wr_full = 1'b0;
   logic        p0_cmd_en;
   logic [2:0]  p0_cmd_instr;
   logic [5:0]  p0_cmd_bl;
   logic [29:0] p0_cmd_byte_addr;
   logic        p0_cmd_full = 1'b0;
   logic [15:0] burst_cnt;
   logic        align_err;
   logic        done;

   mc_wr_burst_issuer #(
      .BURST_LEN (BL),
      .MAX_BURSTS(MAXB),
      .WR_INSTR  (3'b000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .calib_done      (calib_done),
      .src_valid       (src_valid),
      .src_word        (src_word),
      .src_rdy         (src_rdy),
      .p0_wr_en        (p0_wr_en),
      .p0_wr_data      (p0_wr_data),
      .p0_wr_mask      (p0_wr_mask),
      .p0_wr_full      (p0_wr_full),
      .p0_cmd_en       (p0_cmd_en),
      .p0_cmd_instr    (p0_cmd_instr),
      .p0_cmd_bl       (p0_cmd_bl),
      .p0_cmd_byte_addr(p0_cmd_byte_addr),
      .p0_cmd_full     (p0_cmd_full),
      .burst_cnt       (burst_cnt),
      .align_err       (align_err),
      .done            (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic [30:0] src_base = '0;
   int          src_idx = 0;
   int          src_limit = 0;
   bit          src_acc;

   assign src_word = src_base + 31'(src_idx * 4);

   logic [31:0] exp_data_q[$];
   logic [29:0] exp_addr_q[$];
   int          n_cmd = 0;
   int          beats_total = 0;
   int          beats_burst = 0;
   bit          prev_wr = 1'b0;
   bit          prev_cmd = 1'b0;

   typedef struct {
      logic c;
      logic v;
      logic wf;
      logic exp_rdy;
      logic exp_wr;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Source: advances to the next word only after a handshake at the edge.
   initial forever begin
      @(negedge clk);
      src_acc = src_valid && src_rdy;
      @(posedge clk);
      #1;
      if (src_acc) begin
         src_idx++;
         if (src_idx >= src_limit) src_valid = 1'b0;
      end
   end

   // Scoreboard monitor for write beats and command pulses.
   always @(negedge clk) begin
      if (rst) begin
         beats_burst = 0;
         beats_total = 0;
         n_cmd = 0;
         prev_wr = 1'b0;
         prev_cmd = 1'b0;
      end else begin
         if (p0_wr_en) begin
            if (exp_data_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
            else chk("beat_data", p0_wr_data, exp_data_q.pop_front());
            chk("beat_mask", 32'(p0_wr_mask), 32'd0);
         end
         if (p0_cmd_en) begin
            chk("cmd_beats", 32'(beats_burst), 32'(BL));
            chk("cmd_gap", 32'(prev_wr), 32'd0);
            chk("cmd_pulse", 32'(prev_cmd), 32'd0);
            if (exp_addr_q.size() == 0) chk("extra_cmd", 32'd1, 32'd0);
            else chk("cmd_addr", 32'(p0_cmd_byte_addr),
                     32'(exp_addr_q.pop_front()));
            chk("cmd_bl", 32'(p0_cmd_bl), 32'(BL - 1));
            chk("cmd_instr", 32'(p0_cmd_instr), 32'd0);
            beats_burst = 0;
            n_cmd++;
         end
         if (p0_wr_en) begin
            beats_burst++;
            beats_total++;
         end
         prev_wr = p0_wr_en;
         prev_cmd = p0_cmd_en;
      end
   end

   task automatic do_reset(input logic [30:0] base);
      rst = 1'b1;
      src_valid = 1'b0;
      calib_done = 1'b0;
      p0_wr_full = 1'b0;
      p0_cmd_full = 1'b0;
      step();
      step();
      src_base = base;
      src_idx = 0;
      rst = 1'b0;
   endtask

   task automatic push_beats(input int first, input int n);
      for (int i = first; i < first + n; i++)
         exp_data_q.push_back({1'b0, src_base + 31'(i * 4)});
   endtask

   task automatic wait_cmds(input int n, input int budget, input string nm);
      int k = 0;
      while (n_cmd < n && k < budget) begin
         step();
         k++;
      end
      chk(nm, 32'(n_cmd), 32'(n));
   endtask

   task automatic wait_beats(input int n, input int budget, input string nm);
      int k = 0;
      while (beats_total < n && k < budget) begin
         step();
         k++;
      end
      chk(nm, 32'(beats_total), 32'(n));
   endtask

   task automatic go(input int limit);
      src_limit = limit;
      calib_done = 1'b1;
      src_valid = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", passes, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

      // Reset state, with a valid source pushing while rst is held.
      rst = 1'b1;
      src_valid = 1'b1;
      src_limit = 100;
      repeat (3) step();
      @(negedge clk);
      chk("rst_src_rdy", 32'(src_rdy), 32'd0);
      chk("rst_wr_en", 32'(p0_wr_en), 32'd0);
      chk("rst_cmd_en", 32'(p0_cmd_en), 32'd0);
      chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
      chk("rst_align_err", 32'(align_err), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cmd_addr", 32'(p0_cmd_byte_addr), 32'd0);

      // Calibration pending: nothing is accepted for 20 cycles.
      step();
      rst = 1'b0;
      calib_done = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (src_rdy !== 1'b0 || p0_wr_en !== 1'b0 || p0_cmd_en !== 1'b0)
            bad++;
         step();
      end
      chk("wait_cal_idle", 32'(bad), 32'd0);

      // Vector table: ready gating through WAIT_CAL -> FILL.
      for (int i = 0; i < 8; i++) begin
         calib_done = tbl[i].c;
         src_valid = tbl[i].v;
         p0_wr_full = tbl[i].wf;
         @(negedge clk);
         chk($sformatf("vec%0d_rdy", i), 32'(src_rdy), 32'(tbl[i].exp_rdy));
         chk($sformatf("vec%0d_wr", i), 32'(p0_wr_en), 32'(tbl[i].exp_wr));
         step();
      end

      // Single aligned burst.
      do_reset(31'h1000);
      push_beats(0, BL);
      exp_addr_q.push_back(30'h1000);
      go(BL);
      wait_cmds(1, 100, "t2_cmd_seen");
      chk("t2_burst_cnt", 32'(burst_cnt), 32'd1);
      step();
      step();
      @(negedge clk);
      chk("t2_fill_resume", 32'(src_rdy), 32'd1);
      chk("t2_done", 32'(done), 32'd0);
      chk("t2_q_empty", 32'(exp_data_q.size()), 32'd0);

      // Write FIFO full for 3 cycles after beat 4.
      do_reset(31'h2000);
      push_beats(0, BL);
      exp_addr_q.push_back(30'h2000);
      go(BL);
      wait_beats(4, 100, "t3_four_beats");
      p0_wr_full = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (src_rdy !== 1'b0) bad++;
         step();
      end
      p0_wr_full = 1'b0;
      chk("t3_rdy_low", 32'(bad), 32'd0);
      chk("t3_beats_held", 32'(beats_total), 32'd4);
      wait_cmds(1, 100, "t3_cmd_seen");
      chk("t3_beats_total", 32'(beats_total), 32'(BL));
      chk("t3_q_empty", 32'(exp_data_q.size()), 32'd0);

      // Command FIFO full for 5 cycles once the burst is loaded.
      do_reset(31'h3000);
      push_beats(0, BL);
      exp_addr_q.push_back(30'h3000);
      p0_cmd_full = 1'b1;
      go(BL);
      wait_beats(BL, 100, "t4_beats");
      @(negedge clk);
      chk("t4_issue_rdy", 32'(src_rdy), 32'd0);
      repeat (5) step();
      chk("t4_no_cmd", 32'(n_cmd), 32'd0);
      p0_cmd_full = 1'b0;
      wait_cmds(1, 20, "t4_cmd_seen");
      chk("t4_burst_cnt", 32'(burst_cnt), 32'd1);
      step();
      step();
      @(negedge clk);
      chk("t4_fill_resume", 32'(src_rdy), 32'd1);
      chk("t4_one_cmd", 32'(n_cmd), 32'd1);

      // Burst limit with a continuous source.
      do_reset(31'h1000);
      push_beats(0, 2 * BL);
      exp_addr_q.push_back(30'h1000);
      exp_addr_q.push_back(30'h1020);
      go(1000);
      wait_cmds(2, 200, "t5_cmds");
      @(negedge clk);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_burst_cnt", 32'(burst_cnt), 32'd2);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (src_rdy !== 1'b0 || done !== 1'b1) bad++;
      end
      chk("t5_terminal", 32'(bad), 32'd0);
      chk("t5_cmd_count", 32'(n_cmd), 32'd2);
      chk("t5_q_empty", 32'(exp_data_q.size()), 32'd0);

      // Misaligned first word, then reset mid-FILL.
      do_reset(31'h1002);
      push_beats(0, BL);
      exp_addr_q.push_back(30'h1000);
      go(BL);
      wait_cmds(1, 100, "t6_cmd_seen");
      chk("t6_align_err", 32'(align_err), 32'd1);
      step();
      step();
      push_beats(BL, 3);
      src_limit = BL + 3;
      src_valid = 1'b1;
      wait_beats(BL + 3, 100, "t6_partial");
      chk("t6_align_sticky", 32'(align_err), 32'd1);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("t6_rst_src_rdy", 32'(src_rdy), 32'd0);
      chk("t6_rst_wr_en", 32'(p0_wr_en), 32'd0);
      chk("t6_rst_cmd_en", 32'(p0_cmd_en), 32'd0);
      chk("t6_rst_burst_cnt", 32'(burst_cnt), 32'd0);
      chk("t6_rst_align_err", 32'(align_err), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      chk("t6_rst_cmd_addr", 32'(p0_cmd_byte_addr), 32'd0);

      // A full burst after reset proves the beat counter restarted at 0.
      do_reset(31'h4000);
      push_beats(0, BL);
      exp_addr_q.push_back(30'h4000);
      go(BL);
      wait_cmds(1, 100, "t6_post_rst_cmd");
      chk("t6_post_align", 32'(align_err), 32'd0);
      chk("t6_q_empty", 32'(exp_data_q.size()), 32'd0);
      chk("t6_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
